uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_fifo_drain.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and baud divisor.
// Used by uart_tx_fifo_drain (optional parity via UART_TX_PARITY_EN).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  // Clocks per bit, truncated; shared with the receiver.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1, flags the last clk of each bit.
// Synchronous clear holds it at zero.
module uart_baud_gen #(
  parameter int BAUD_DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_bit_end = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter draining a byte FIFO; define UART_TX_PARITY_EN
// to insert an even-parity bit between data and stop.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] r_data,
  output logic       rd,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nx;
  logic [7:0] r_shift;
  logic       r_tx;
  logic       w_tx_nx;
  logic       w_clr;
  logic       w_bit_end;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_clr     (w_clr),
    .o_bit_end (w_bit_end)
  );

  assign tx      = r_tx;
  assign tx_busy = (r_state != IDLE);

  // tx is computed one clk ahead so the line comes straight from a flop.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_tx_nx    = r_tx;
    w_clr      = 1'b0;
    rd         = 1'b0;
    tx_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clr   = 1'b1;
        w_tx_nx = 1'b1;
        if (!empty) begin
          rd         = !reset;
          w_state_nx = START;
          w_idx_nx   = 3'd0;
          w_tx_nx    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
          w_idx_nx   = 3'd0;
          w_tx_nx    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_state_nx = PARITY;
            w_tx_nx    = ^r_shift;
`else
            w_state_nx = STOP;
            w_tx_nx    = 1'b1;
`endif
          end else begin
            w_idx_nx = r_idx + 3'd1;
            w_tx_nx  = r_shift[w_idx_nx];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nx = STOP;
          w_tx_nx    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          tx_done    = 1'b1;
          w_state_nx = IDLE;
          w_tx_nx    = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
      if (rd) begin
        r_shift <= r_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with BAUD_DIV=10.
// Build with UART_TX_PARITY_EN to exercise the parity frame.
module tb_uart_tx_fifo_drain;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 110;
`else
  localparam int FL = 100;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [7:0] r_data;
  logic       rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_fifo_drain #(
    .CLK_FREQ  (1000),
    .BAUD_RATE (100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .empty   (empty),
    .r_data  (r_data),
    .rd      (rd),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int         n_run  = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  bit         use_q  = 1'b0;
  logic       s_tx, s_rd, s_busy, s_done, s_par;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic qsync();
    if (use_q) begin
      empty  = (q.size() == 0);
      r_data = empty ? 8'h00 : q[0];
    end
  endtask

  // Sample on the falling edge, let the FIFO model pop after the rising one.
  task automatic cyc();
    @(negedge clk);
    s_tx   = tx;
    s_rd   = rd;
    s_busy = tx_busy;
    s_done = tx_done;
    @(posedge clk);
    #1;
    if (use_q && s_rd && q.size() > 0) void'(q.pop_front());
    qsync();
  endtask

  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int b;
    b = (k - 1) / 10;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic wait_rd(input string tag, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (s_rd === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_rd_seen"}, got, 1);
  endtask

  // Called right after the rd clk has been sampled.
  task automatic frame(input string tag, input logic [7:0] d, input bit mid);
    int         mism, done_at, ndone, busy, rds;
    logic [7:0] dec;
    mism = 0; done_at = -1; ndone = 0; busy = 0; rds = 0; dec = 8'h00;
    for (int k = 1; k <= FL; k++) begin
      cyc();
      if (s_tx !== exp_tx(d, k)) mism++;
      if (s_done === 1'b1) begin
        done_at = k;
        ndone++;
      end
      if (s_busy === 1'b1) busy++;
      if (s_rd !== 1'b0) rds++;
      if (k >= 11 && k <= 90 && (k % 10) == 5) dec[(k-11)/10] = s_tx;
      if (k == 95) s_par = s_tx;
      if (mid && k == 20) begin
        r_data = 8'hAA;
        empty  = 1'b0;
      end
    end
    chk({tag, "_wave_mism"}, mism, 0);
    chk({tag, "_byte"}, int'(dec), int'(d));
    chk({tag, "_done_at"}, done_at, FL);
    chk({tag, "_done_cnt"}, ndone, 1);
    chk({tag, "_busy_clks"}, busy, FL);
    chk({tag, "_rd_in_frame"}, rds, 0);
  endtask

  initial begin
    int bad;
    reset  = 1'b1;
    empty  = 1'b1;
    r_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_rd", int'(rd), 0);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    empty = 1'b0;
    #1;
    chk("rst_rd_nonempty", int'(rd), 0);
    empty = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    bad = 0;
    repeat (200) begin
      cyc();
      if (s_tx !== 1'b1 || s_rd !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) bad++;
    end
    chk("idle200_bad", bad, 0);

    use_q = 1'b1;
    q.push_back(8'hA5);
    qsync();
    wait_rd("a5", 5);
    frame("a5", 8'hA5, 1'b0);
    bad = 0;
    repeat (20) begin
      cyc();
      if (s_rd !== 1'b0 || s_tx !== 1'b1) bad++;
    end
    chk("a5_after_bad", bad, 0);

    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h3C);
    qsync();
    wait_rd("b0", 5);
    frame("b0", 8'h00, 1'b0);
    cyc();
    chk("b1_rd_spacing", int'(s_rd), 1);
    frame("b1", 8'hFF, 1'b0);
    cyc();
    chk("b2_rd_spacing", int'(s_rd), 1);
    frame("b2", 8'h3C, 1'b0);
    chk("b_empty_after", int'(empty), 1);
    bad = 0;
    repeat (150) begin
      cyc();
      if (s_rd !== 1'b0) bad++;
    end
    chk("b_no_extra_rd", bad, 0);

    use_q  = 1'b0;
    empty  = 1'b0;
    r_data = 8'h55;
    wait_rd("m55", 5);
    empty = 1'b1;
    frame("m55", 8'h55, 1'b1);
    cyc();
    chk("mAA_rd_next", int'(s_rd), 1);
    empty = 1'b1;
    frame("mAA", 8'hAA, 1'b0);

    empty  = 1'b0;
    r_data = 8'h81;
    wait_rd("r81", 5);
    empty = 1'b1;
    repeat (34) cyc();
    @(negedge clk);
    chk("rst_mid_pre_tx", int'(tx), 0);
    chk("rst_mid_pre_busy", int'(tx_busy), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_busy", int'(tx_busy), 0);
    chk("rst_mid_done", int'(tx_done), 0);
    empty = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
    chk("rst_rel_rd_first", int'(s_rd), 1);
    empty = 1'b1;
    frame("r81", 8'h81, 1'b0);

`ifdef UART_TX_PARITY_EN
    empty  = 1'b0;
    r_data = 8'h07;
    wait_rd("p07", 5);
    empty = 1'b1;
    frame("p07", 8'h07, 1'b0);
    chk("p07_parity", int'(s_par), 1);
    empty  = 1'b0;
    r_data = 8'h03;
    wait_rd("p03", 5);
    empty = 1'b1;
    frame("p03", 8'h03, 1'b0);
    chk("p03_parity", int'(s_par), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
